// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the eight clients and the round-robin arbiter.
// The arbiter connects through the slave modport; the requester side uses master.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered one-hot grant and binary index.
// Define ARB_TIMEOUT_EN to add forced release after MAX_HOLD cycles plus a re-request mask.
module rr_arbiter8 #(
  parameter int PTR_RST  = 0,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter8_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  if (PTR_RST < 0 || PTR_RST > 7 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
    $error("rr_arbiter8: PTR_RST or MAX_HOLD out of range");
  end

  state_t     state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [7:0] gnt_reg, gnt_next;
  logic [2:0] idx_reg, idx_next;
  logic       timeout_reg, timeout_next;

  logic       holder_req;
  logic       forced;
  logic       new_grant;
  logic [7:0] mask;
  logic [7:0] elig;
  logic [2:0] search_start;
  logic [7:0] rot;
  logic       found;
  logic [2:0] offset;
  logic [2:0] win;

  assign holder_req = bus.req[idx_reg];

  // The current holder never competes in its own handoff search; that matters
  // only for a forced release, where its request is still high.
  assign elig         = bus.req & ~mask & ((state_reg == GRANT) ? ~gnt_reg : 8'hFF);
  assign search_start = (state_reg == GRANT) ? idx_reg + 3'd1 : ptr_reg;

  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    assign rot[gi] = elig[search_start + 3'(gi)];
  end

  always_comb begin
    found  = 1'b0;
    offset = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot[k]) begin
        found  = 1'b1;
        offset = 3'(k);
      end
    end
  end

  assign win = search_start + offset;

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    gnt_next     = gnt_reg;
    idx_next     = idx_reg;
    timeout_next = forced;
    new_grant    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next = GRANT;
          gnt_next   = 8'b1 << win;
          idx_next   = win;
          new_grant  = 1'b1;
        end else begin
          gnt_next = 8'h00;
          idx_next = 3'd0;
        end
      end
      GRANT: begin
        if (!holder_req || forced) begin
          ptr_next = idx_reg + 3'd1;
          if (found) begin
            gnt_next  = 8'b1 << win;
            idx_next  = win;
            new_grant = 1'b1;
          end else begin
            state_next = IDLE;
            gnt_next   = 8'h00;
            idx_next   = 3'd0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 8'h00;
        idx_next   = 3'd0;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_reg, hold_cnt_next;
  logic [7:0] mask_reg, mask_next;

  assign forced = (state_reg == GRANT) && holder_req && (hold_cnt_reg == 8'(MAX_HOLD - 1));
  assign mask   = mask_reg;

  always_comb begin
    hold_cnt_next = hold_cnt_reg + 8'd1;
    if (new_grant || state_next == IDLE) begin
      hold_cnt_next = 8'd0;
    end
    // A masked requester becomes eligible again once it has been seen idle.
    mask_next = (mask_reg & bus.req) | (forced ? gnt_reg : 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_reg <= 8'd0;
      mask_reg     <= 8'h00;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      mask_reg     <= mask_next;
    end
  end
`else
  assign forced = 1'b0;
  assign mask   = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= 3'(PTR_RST);
      gnt_reg     <= 8'h00;
      idx_reg     <= 3'd0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      gnt_reg     <= gnt_next;
      idx_reg     <= idx_next;
      timeout_reg <= timeout_next;
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.gnt_idx   = idx_reg;
  assign bus.gnt_valid = |gnt_reg;
  assign bus.timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, handoff, rotation, encoding and optional timeout.
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.PTR_RST(0), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected idle/grant state given the winning index (valid=0 means no grant).
  task automatic chk_out(input string tag, input logic v, input logic [2:0] idx, input logic t);
    logic [7:0] g;
    g = v ? (8'b1 << idx) : 8'h00;
    chk({tag, ".gnt"}, bus.gnt, g);
    chk({tag, ".idx"}, {5'd0, bus.gnt_idx}, v ? {5'd0, idx} : 8'h00);
    chk({tag, ".valid"}, {7'd0, bus.gnt_valid}, {7'd0, v});
    chk({tag, ".timeout"}, {7'd0, bus.timeout}, {7'd0, t});
    $display("step %s req=%02h gnt=%02h idx=%0d valid=%0b timeout=%0b",
             tag, bus.req, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout);
  endtask

  initial begin
    rst_n   = 1'b1;
    bus.req = 8'h00;
    #2 rst_n = 1'b0;
    step();
    step();
    chk_out("reset", 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("idle", 1'b0, 3'd0, 1'b0);

    // Single request, then release sets ptr to 3.
    bus.req = 8'b0000_0100;
    step(); chk_out("single", 1'b1, 3'd2, 1'b0);
    step(); chk_out("single_hold", 1'b1, 3'd2, 1'b0);
    bus.req = 8'h00;
    step(); chk_out("single_rel", 1'b0, 3'd0, 1'b0);

    // Rotation from ptr=3 with wrap: 7, 0, 1, no idle cycle between.
    bus.req = 8'b1000_0011;
    step(); chk_out("rr_7", 1'b1, 3'd7, 1'b0);
    step(); chk_out("rr_7_hold", 1'b1, 3'd7, 1'b0);
    bus.req = 8'b0000_0011;
    step(); chk_out("rr_0", 1'b1, 3'd0, 1'b0);
    bus.req = 8'b0000_0010;
    step(); chk_out("rr_1", 1'b1, 3'd1, 1'b0);
    bus.req = 8'h00;
    step(); chk_out("rr_idle", 1'b0, 3'd0, 1'b0);

    // Move ptr to 0 via a grant to 7.
    bus.req = 8'h80;
    step(); chk_out("to_ptr0", 1'b1, 3'd7, 1'b0);
    bus.req = 8'h00;
    step(); chk_out("ptr0_idle", 1'b0, 3'd0, 1'b0);

    // Contention: 1, 4, 6, then 1 again as 6 drops and 1 re-requests.
    bus.req = 8'b0101_0010;
    step(); chk_out("ct_1", 1'b1, 3'd1, 1'b0);
    repeat (3) begin step(); chk_out("ct_1_hold", 1'b1, 3'd1, 1'b0); end
    bus.req = 8'b0101_0000;
    step(); chk_out("ct_4", 1'b1, 3'd4, 1'b0);
    repeat (3) begin step(); chk_out("ct_4_hold", 1'b1, 3'd4, 1'b0); end
    bus.req = 8'b0100_0000;
    step(); chk_out("ct_6", 1'b1, 3'd6, 1'b0);
    repeat (3) begin step(); chk_out("ct_6_hold", 1'b1, 3'd6, 1'b0); end
    bus.req = 8'b0000_0010;
    step(); chk_out("ct_1_again", 1'b1, 3'd1, 1'b0);
    bus.req = 8'h00;
    step(); chk_out("ct_idle", 1'b0, 3'd0, 1'b0);

    // Encoding walk over every single requester.
    for (int i = 0; i < 8; i++) begin
      bus.req = 8'b1 << i;
      step(); chk_out("walk", 1'b1, 3'(i), 1'b0);
      bus.req = 8'h00;
      step(); chk_out("walk_idle", 1'b0, 3'd0, 1'b0);
    end

    // Asynchronous reset in the middle of a grant.
    bus.req = 8'h08;
    step(); chk_out("pre_rst", 1'b1, 3'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 1'b0, 3'd0, 1'b0);
    bus.req = 8'h00;
    step();
    rst_n = 1'b1;
    step(); chk_out("post_rst", 1'b0, 3'd0, 1'b0);

    // Fairness with all eight requesting; ptr restarts at 0 after reset.
    bus.req = 8'hFF;
    step(); chk_out("fair_0", 1'b1, 3'd0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      bus.req = 8'hFF & ~(8'b1 << (k % 8));
      step(); chk_out("fair", 1'b1, 3'((k + 1) % 8), 1'b0);
      bus.req = 8'hFF;
      step(); chk_out("fair_hold", 1'b1, 3'((k + 1) % 8), 1'b0);
    end
    bus.req = 8'h00;
    step(); chk_out("fair_idle", 1'b0, 3'd0, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // ptr=2: idx 0 wins, held 4 cycles, forced off, idx 1 takes over.
    bus.req = 8'b0000_0011;
    step(); chk_out("to_0", 1'b1, 3'd0, 1'b0);
    repeat (3) begin step(); chk_out("to_0_hold", 1'b1, 3'd0, 1'b0); end
    step(); chk_out("to_fire", 1'b1, 3'd1, 1'b1);
    step(); chk_out("to_1_hold", 1'b1, 3'd1, 1'b0);
    bus.req = 8'b0000_0001;
    step(); chk_out("to_masked", 1'b0, 3'd0, 1'b0);
    step(); chk_out("to_masked2", 1'b0, 3'd0, 1'b0);
    bus.req = 8'h00;
    step(); chk_out("to_unmask", 1'b0, 3'd0, 1'b0);
    bus.req = 8'b0000_0001;
    step(); chk_out("to_regrant", 1'b1, 3'd0, 1'b0);
    bus.req = 8'h00;
    step(); chk_out("to_idle", 1'b0, 3'd0, 1'b0);
`else
    // Without the timeout feature a grant is held indefinitely.
    bus.req = 8'b0000_0011;
    step(); chk_out("long_0", 1'b1, 3'd0, 1'b0);
    repeat (20) begin step(); chk_out("long_hold", 1'b1, 3'd0, 1'b0); end
    bus.req = 8'b0000_0010;
    step(); chk_out("long_1", 1'b1, 3'd1, 1'b0);
    bus.req = 8'h00;
    step(); chk_out("long_idle", 1'b0, 3'd0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter that shares one resource between eight clients.
- Outputs a one-hot grant plus the 3-bit binary index of the granted requester. The index is the same encoding an 8x3 encoder gives for that one-hot grant.
- Sits in front of the shared datapath; gnt_idx drives the datapath select mux.

Parameters:
- PTR_RST, 0, priority pointer value after reset (0..7).
- MAX_HOLD, 16, grant cycle limit before forced release. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  8  level request per requester; bit i = requester i.
- gnt  out  8  one-hot grant, registered.
- gnt_idx  out  3  binary index of the granted requester, registered; 0 when gnt_valid=0.
- gnt_valid  out  1  high while any grant is held.
- timeout  out  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset: one clock domain, clk. rst_n is asynchronous, active-low.
  - Reset clears gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, state=IDLE, ptr=PTR_RST, hold_cnt=0.
  - Reset asserted mid-grant drops the grant immediately (asynchronously). There is no release handshake.
- States: IDLE, GRANT.
- Winner search: circular, starting at ptr and running ptr, ptr+1, ..., ptr+7 (mod 8). The first set bit of the eligible request vector wins. Combinational, evaluated every cycle.
- IDLE:
  - If req != 0, the winner is registered at the next edge: gnt = 1<<w, gnt_idx = w, gnt_valid = 1, state goes to GRANT.
  - Latency from req rising to gnt is exactly 1 clock.
  - If req == 0, the block stays in IDLE with all outputs 0.
- GRANT:
  - The grant holds while req[gnt_idx] = 1. Other requests never preempt it.
  - Release happens when req[gnt_idx] is sampled 0. On that edge ptr <= gnt_idx+1; the mod-8 wrap sends 7 to 0.
  - Back-to-back handoff: the search for the next grant starts at gnt_idx+1 (same edge, no idle cycle).
    - If any other request is pending, the new grant is registered on the release edge.
    - Otherwise the block returns to IDLE with gnt = 0, gnt_idx = 0, gnt_valid = 0.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_idx equals the encoded gnt.
  - gnt_valid equals |gnt.
- Simultaneous events:
  - A requester that drops req while another raises it on the same edge: the handoff rules above apply.
  - A requester raising req in the same cycle it would win is treated as eligible. There is no extra sampling delay.
- Fairness: with all 8 requesting continuously and each releasing after its turn, grants rotate 0,1,...,7,0. Worst-case wait is 7 grant tenures.
- ptr changes only on release or forced release, never in IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold_cnt clears on every new grant and increments each GRANT cycle.
  - When hold_cnt reaches MAX_HOLD-1 while req[gnt_idx] is still 1, the release is forced: timeout pulses high for 1 cycle on that edge, ptr advances, and handoff follows the normal rules.
  - The timed-out requester is masked from the search until its req is sampled 0 once. The mask is cleared by reset.
  - A normal release on the same edge as the limit takes precedence; no timeout pulse.
- Undefined: no counter and no mask; timeout tied 0; a grant is held indefinitely.

Test Plan:
- Reset with PTR_RST=0: req=8'h00 -> gnt=0, gnt_idx=0, gnt_valid=0. Assert rst_n=0 mid-grant -> all outputs 0 without waiting for clk.
- Single request: req=8'b0000_0100 -> one cycle later gnt=8'h04, gnt_idx=3'd2. Drop req -> next edge gnt=0, ptr=3.
- Round-robin: ptr=3, req=8'b1000_0011 -> grant idx 7, then 0, then 1, each after the holder drops. Handoff has zero idle cycles.
- Contention with wrap: ptr=0, req=8'b0101_0010 held, each requester drops 4 cycles after its grant -> grant order 1, 4, 6, then 1 again once it re-requests.
- Encoding check: walk single request bits 0..7 -> gnt_idx = 0..7; gnt stays one-hot at every cycle.
- ARB_TIMEOUT_EN with MAX_HOLD=4, req=8'b0000_0011 held -> idx 0 granted for 4 cycles, timeout pulses, idx 1 granted. Idx 0 is not regranted until its req drops and rises again.
